// File: rtl/life_pkg.sv
// Shared board geometry, grid/index types and serializer FSM states for the Life engine.
package life_pkg;

  localparam int LIFE_ROWS = 10;
  localparam int LIFE_COLS = 10;

  typedef logic [LIFE_ROWS-1:0][LIFE_COLS-1:0] life_grid_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  typedef logic [$clog2(LIFE_ROWS)-1:0] row_idx_t;
  typedef logic [$clog2(LIFE_COLS)-1:0] col_idx_t;

endpackage

// File: rtl/life_grid_serializer.sv
// Snapshots a Life generation and streams it cell by cell (row 0 first, leftmost column first).
// Optional live-cell popcount outputs are enabled by defining LIFE_SER_POPCOUNT_EN.
module life_grid_serializer
  import life_pkg::*;
#(
  parameter int ROWS   = LIFE_ROWS,
  parameter int COLS   = LIFE_COLS,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ROWS-1:0][COLS-1:0]  grid,
  input  logic                       grid_valid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_cell,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic                       out_eof,
  output logic                       busy,
  output logic [DROP_W-1:0]          drop_count
`ifdef LIFE_SER_POPCOUNT_EN
  ,
  output logic [$clog2(ROWS*COLS+1)-1:0] pop_count,
  output logic                           pop_valid
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] FIRST_COL = CW'(COLS - 1);

  ser_state_t               state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic [ROWS-1:0][COLS-1:0] snap_q, snap_d;
  logic [DROP_W-1:0]        drop_q, drop_d;

  logic xfer, at_last, capture, cur_cell;

`ifdef LIFE_SER_POPCOUNT_EN
  localparam int PW = $clog2(ROWS*COLS + 1);
  logic [PW-1:0] acc_q, acc_d, pop_count_q, pop_count_d;
  logic          pop_valid_q, pop_valid_d;
`endif

  assign at_last  = (row_q == LAST_ROW) && (col_q == '0);
  assign xfer     = (state_q == SEND) && out_ready;
  assign cur_cell = snap_q[row_q][col_q];
  // A new grid is taken when idle, or on the final transfer so the next frame follows without a bubble.
  assign capture  = grid_valid && ((state_q == IDLE) || (xfer && at_last));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      snap_q  <= '0;
      drop_q  <= '0;
`ifdef LIFE_SER_POPCOUNT_EN
      acc_q       <= '0;
      pop_count_q <= '0;
      pop_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      snap_q  <= snap_d;
      drop_q  <= drop_d;
`ifdef LIFE_SER_POPCOUNT_EN
      acc_q       <= acc_d;
      pop_count_q <= pop_count_d;
      pop_valid_q <= pop_valid_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    snap_d  = snap_q;
    drop_d  = drop_q;
    if (capture) begin
      snap_d  = grid;
      row_d   = '0;
      col_d   = FIRST_COL;
      state_d = SEND;
    end else if (xfer) begin
      if (at_last) begin
        state_d = IDLE;
        row_d   = '0;
        col_d   = '0;
      end else if (col_q == '0) begin
        col_d = FIRST_COL;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q - CW'(1);
      end
    end
    if (grid_valid && (state_q == SEND) && !(xfer && at_last) && (drop_q != '1)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

`ifdef LIFE_SER_POPCOUNT_EN
  always_comb begin
    acc_d       = acc_q;
    pop_count_d = pop_count_q;
    pop_valid_d = 1'b0;
    if (xfer) begin
      acc_d = acc_q + PW'(cur_cell);
      if (at_last) begin
        pop_count_d = acc_q + PW'(cur_cell);
        pop_valid_d = 1'b1;
      end
    end
    if (capture) begin
      acc_d = '0;
    end
  end

  assign pop_count = pop_count_q;
  assign pop_valid = pop_valid_q;
`endif

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    out_cell  = 1'b0;
    out_sof   = 1'b0;
    out_eol   = 1'b0;
    out_eof   = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      busy      = 1'b1;
      out_cell  = cur_cell;
      out_sof   = (row_q == '0) && (col_q == FIRST_COL);
      out_eol   = (col_q == '0);
      out_eof   = at_last;
    end
  end

  assign drop_count = drop_q;

endmodule

// File: tb/tb_life_grid_serializer.sv
// Self-checking bench for life_grid_serializer: directed and random frames against a
// reference model of the stream order, markers, drop counter and (optionally) popcount.
module tb_life_grid_serializer;
   import life_pkg::*;

   localparam int R = LIFE_ROWS;
   localparam int C = LIFE_COLS;
   localparam int N = R * C;

   logic       clk = 1'b0;
   logic       reset;
   life_grid_t grid;
   logic       grid_valid;
   logic       out_valid;
   logic       out_ready;
   logic       out_cell;
   logic       out_sof;
   logic       out_eol;
   logic       out_eof;
   logic       busy;
   logic [7:0] drop_count;
`ifdef LIFE_SER_POPCOUNT_EN
   logic [6:0] pop_count;
   logic       pop_valid;
`endif

   int total = 0;
   int bad = 0;
   int dropModel = 0;

   life_grid_serializer dut (
      .clk(clk),
      .reset(reset),
      .grid(grid),
      .grid_valid(grid_valid),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_cell(out_cell),
      .out_sof(out_sof),
      .out_eol(out_eol),
      .out_eof(out_eof),
      .busy(busy),
      .drop_count(drop_count)
`ifdef LIFE_SER_POPCOUNT_EN
      ,
      .pop_count(pop_count),
      .pop_valid(pop_valid)
`endif
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Random board, one row word at a time
   function automatic life_grid_t randomGrid();
      life_grid_t g;
      for (int r = 0; r < R; r++) g[r] = LIFE_COLS'($urandom());
      return g;
   endfunction

   // Live cells on a board
   function automatic int popModel(input life_grid_t g);
      int n = 0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++)
            n += int'(g[r][c]);
      return n;
   endfunction

   // Cell at stream position idx: row-major, leftmost (highest bit) column first
   function automatic logic expCell(input life_grid_t g, input int idx);
      return g[idx / C][C - 1 - (idx % C)];
   endfunction

   // Single comparison point; every check funnels through here
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive inputs for the next active edge
   task automatic applyStimulus(input logic rdy, input logic gv, input life_grid_t g);
      out_ready  = rdy;
      grid_valid = gv;
      grid       = g;
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle grid_valid pulse, then scramble grid to show it is only sampled at capture
   task automatic startFrame(input life_grid_t g);
      applyStimulus(1'b0, 1'b1, g);
      tick();
      applyStimulus(1'b0, 1'b0, randomGrid());
   endtask

   // Drain one frame. mode: 0 ready high, 1 ready toggling, 2 random ready.
   // dropPulses grid_valid pulses (with ready stalled) are issued from transfer dropAt onward.
   // b2b raises grid_valid with nextGrid on the eof transfer. abortAt applies reset at that transfer.
   task automatic receiveFrame(input life_grid_t g, input int mode, input int dropAt, input int dropPulses,
                               input bit b2b, input life_grid_t nextGrid, input int abortAt);
      int idx = 0;
      int cycles = 0;
      int left = dropPulses;
      logic rdy;
      logic gv;
      life_grid_t drive;
      while (idx < N && cycles < 2000) begin
         if (idx == abortAt) begin
            reset = 1'b1;
            applyStimulus(1'b0, 1'b0, randomGrid());
            tick();
            reset = 1'b0;
            dropModel = 0;
            checkOutput("abort_valid", 32'(out_valid), 32'd0);
            checkOutput("abort_busy", 32'(busy), 32'd0);
            checkOutput("abort_drop", 32'(drop_count), 32'd0);
            checkOutput("abort_sof", 32'(out_sof), 32'd0);
            return;
         end
         checkOutput("valid", 32'(out_valid), 32'd1);
         checkOutput("busy", 32'(busy), 32'd1);
         checkOutput("cell", 32'(out_cell), 32'(expCell(g, idx)));
         checkOutput("sof", 32'(out_sof), 32'(idx == 0));
         checkOutput("eol", 32'(out_eol), 32'(idx % C == C - 1));
         checkOutput("eof", 32'(out_eof), 32'(idx == N - 1));
         drive = randomGrid();
         gv = 1'b0;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = (cycles % 2 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         if (b2b && idx == N - 1) rdy = 1'b1;
         if (left > 0 && idx >= dropAt) begin
            rdy = 1'b0;
            gv = 1'b1;
            left--;
            if (dropModel < 255) dropModel++;
         end else if (b2b && idx == N - 1) begin
            gv = 1'b1;
            drive = nextGrid;
         end
         applyStimulus(rdy, gv, drive);
         tick();
         if (rdy) idx++;
         cycles++;
      end
      applyStimulus(1'b0, 1'b0, randomGrid());
      checkOutput("frame_len", 32'(idx), 32'(N));
      checkOutput("drop_count", 32'(drop_count), 32'(dropModel));
`ifdef LIFE_SER_POPCOUNT_EN
      checkOutput("pop_valid", 32'(pop_valid), 32'd1);
      checkOutput("pop_count", 32'(pop_count), 32'(popModel(g)));
`endif
      if (!b2b) begin
         checkOutput("end_valid", 32'(out_valid), 32'd0);
         checkOutput("end_busy", 32'(busy), 32'd0);
      end
   endtask

   // Directed sequence followed by random frames
   initial begin
      life_grid_t blinker;
      life_grid_t ones;
      life_grid_t g;
      life_grid_t g2;
      blinker = '0;
      blinker[5] = 10'b0000111000;
      ones = '1;

      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, '0);
      tick();
      tick();
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_cell", 32'(out_cell), 32'd0);
      checkOutput("rst_sof", 32'(out_sof), 32'd0);
      checkOutput("rst_eol", 32'(out_eol), 32'd0);
      checkOutput("rst_eof", 32'(out_eof), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_drop", 32'(drop_count), 32'd0);
      reset = 1'b0;
      tick();
      checkOutput("idle_valid", 32'(out_valid), 32'd0);

      $display("[TB] blinker, ready high");
      startFrame(blinker);
      receiveFrame(blinker, 0, -1, 0, 1'b0, '0, -1);

      $display("[TB] blinker, ready toggling");
      startFrame(blinker);
      receiveFrame(blinker, 1, -1, 0, 1'b0, '0, -1);

      $display("[TB] single drop at transfer 40");
      startFrame(blinker);
      receiveFrame(blinker, 0, 40, 1, 1'b0, '0, -1);

      $display("[TB] 300 drops, saturating counter");
      g = randomGrid();
      startFrame(g);
      receiveFrame(g, 2, 40, 300, 1'b0, '0, -1);

      $display("[TB] back-to-back frames");
      startFrame(blinker);
      receiveFrame(blinker, 0, -1, 0, 1'b1, ones, -1);
      receiveFrame(ones, 0, -1, 0, 1'b0, '0, -1);

      $display("[TB] random frames");
      for (int k = 0; k < 4; k++) begin
         g = randomGrid();
         g2 = randomGrid();
         startFrame(g);
         receiveFrame(g, 2, -1, 0, 1'b1, g2, -1);
         receiveFrame(g2, 2, -1, 0, 1'b0, '0, -1);
      end

      $display("[TB] reset mid-frame");
      g = randomGrid();
      startFrame(g);
      receiveFrame(g, 0, -1, 0, 1'b0, '0, 30);
      tick();
      checkOutput("post_abort_valid", 32'(out_valid), 32'd0);
      g2 = randomGrid();
      startFrame(g2);
      receiveFrame(g2, 0, -1, 0, 1'b0, '0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
